// File: rtl/player_movement.sv
// Per-frame ship position integrator with screen clamping, plus the
// alive / hit-invulnerable / dead life state machine feeding the bitmap stage.
module player_movement #(
  parameter int INITIAL_X              = 300,
  parameter int INITIAL_Y              = 420,
  parameter int OBJECT_WIDTH_X         = 32,
  parameter int SCREEN_LEFT            = 0,
  parameter int SCREEN_RIGHT           = 639,
  parameter int FIXED_POINT_MULTIPLIER = 64,
  parameter int X_SPEED                = 128,
  parameter int LIVES                  = 3,
  parameter int HIT_FRAMES             = 60,
  parameter int BLINK_FRAMES           = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startOfFrame,
  input  logic               moveLeft,
  input  logic               moveRight,
  input  logic               playerHit,
  output logic signed [10:0] topLeftX,
  output logic signed [10:0] topLeftY,
  output logic               visible,
  output logic [2:0]         livesLeft,
  output logic               gameOver
);

  localparam int FpShift = $clog2(FIXED_POINT_MULTIPLIER);
  localparam int HitW    = $clog2(HIT_FRAMES + 1);
  localparam int BlinkW  = $clog2(BLINK_FRAMES + 1);

  localparam logic signed [17:0] MinFp = 18'(SCREEN_LEFT * FIXED_POINT_MULTIPLIER);
  localparam logic signed [17:0] MaxFp =
      18'((SCREEN_RIGHT + 1 - OBJECT_WIDTH_X) * FIXED_POINT_MULTIPLIER);
  localparam logic signed [17:0] Speed  = 18'(X_SPEED);
  localparam logic signed [16:0] InitFp = 17'(INITIAL_X * FIXED_POINT_MULTIPLIER);

  typedef enum logic [1:0] {StAlive, StHit, StDead} state_e;

  state_e              state_q, state_d;
  logic signed [16:0]  x_fp_q, x_fp_d;
  logic [2:0]          lives_q, lives_d;
  logic                visible_q, visible_d;
  logic                game_over_q, game_over_d;
  logic [HitW-1:0]     hit_cnt_q, hit_cnt_d;
  logic [BlinkW-1:0]   blink_cnt_q, blink_cnt_d;
  logic signed [17:0]  x_ext, x_move;

  // One extra bit of headroom so the saturation compares cannot wrap.
  always_comb begin
    x_ext  = {x_fp_q[16], x_fp_q};
    x_move = x_ext;
    if (moveLeft && !moveRight) begin
      x_move = x_ext - Speed;
      if (x_move < MinFp) x_move = MinFp;
    end else if (moveRight && !moveLeft) begin
      x_move = x_ext + Speed;
      if (x_move > MaxFp) x_move = MaxFp;
    end
  end

  always_comb begin
    state_d     = state_q;
    x_fp_d      = x_fp_q;
    lives_d     = lives_q;
    visible_d   = visible_q;
    game_over_d = game_over_q;
    hit_cnt_d   = hit_cnt_q;
    blink_cnt_d = blink_cnt_q;
    unique case (state_q)
      StAlive: begin
        // A hit takes priority over a coincident frame's movement.
        if (playerHit) begin
          lives_d   = lives_q - 3'd1;
          visible_d = 1'b0;
          if (lives_q == 3'd1) begin
            state_d     = StDead;
            game_over_d = 1'b1;
          end else begin
            state_d     = StHit;
            hit_cnt_d   = '0;
            blink_cnt_d = '0;
          end
        end else if (startOfFrame) begin
          x_fp_d = 17'(x_move);
        end
      end
      StHit: begin
        if (startOfFrame) begin
          hit_cnt_d = hit_cnt_q + HitW'(1);
          if (blink_cnt_q == BlinkW'(BLINK_FRAMES - 1)) begin
            visible_d   = ~visible_q;
            blink_cnt_d = '0;
          end else begin
            blink_cnt_d = blink_cnt_q + BlinkW'(1);
          end
          if (hit_cnt_q == HitW'(HIT_FRAMES - 1)) begin
            state_d     = StAlive;
            visible_d   = 1'b1;
            hit_cnt_d   = '0;
            blink_cnt_d = '0;
          end
        end
      end
      StDead: begin
        visible_d   = 1'b0;
        game_over_d = 1'b1;
      end
      default: state_d = StAlive;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StAlive;
      x_fp_q      <= InitFp;
      lives_q     <= 3'(LIVES);
      visible_q   <= 1'b1;
      game_over_q <= 1'b0;
      hit_cnt_q   <= '0;
      blink_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      x_fp_q      <= x_fp_d;
      lives_q     <= lives_d;
      visible_q   <= visible_d;
      game_over_q <= game_over_d;
      hit_cnt_q   <= hit_cnt_d;
      blink_cnt_q <= blink_cnt_d;
    end
  end

  assign topLeftX  = 11'(x_fp_q >>> FpShift);
  assign topLeftY  = 11'(INITIAL_Y);
  assign visible   = visible_q;
  assign livesLeft = lives_q;
  assign gameOver  = game_over_q;

endmodule

// File: tb/tb_player_movement.sv
// Scoreboard bench for player_movement: a frame-level reference model pushes
// expected outputs per cycle, an independent monitor pops and compares them.
module tb_player_movement;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               startOfFrame = 1'b0;
  logic               moveLeft = 1'b0;
  logic               moveRight = 1'b0;
  logic               playerHit = 1'b0;
  logic signed [10:0] topLeftX;
  logic signed [10:0] topLeftY;
  logic               visible;
  logic [2:0]         livesLeft;
  logic               gameOver;

  always #5 clk = ~clk;

  player_movement dut (
    .clk          (clk),
    .reset        (reset),
    .startOfFrame (startOfFrame),
    .moveLeft     (moveLeft),
    .moveRight    (moveRight),
    .playerHit    (playerHit),
    .topLeftX     (topLeftX),
    .topLeftY     (topLeftY),
    .visible      (visible),
    .livesLeft    (livesLeft),
    .gameOver     (gameOver)
  );

  typedef struct {
    int x;
    int vis;
    int lives;
    int over;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: pixel position in 1/64 px, mode 0=alive 1=hit 2=dead.
  int m_xfp, m_lives, m_mode, m_frames;

  task automatic chk(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("topLeftX", int'(topLeftX), e.x);
        chk("topLeftY", int'(topLeftY), 420);
        chk("visible", int'(visible), e.vis);
        chk("livesLeft", int'(livesLeft), e.lives);
        chk("gameOver", int'(gameOver), e.over);
      end
    end
  end

  task automatic model_step(input bit rst, input bit sof, input bit l, input bit r,
                            input bit hit);
    exp_t e;
    if (rst) begin
      m_xfp = 300 * 64; m_lives = 3; m_mode = 0; m_frames = 0;
    end else if (m_mode == 0) begin
      if (hit) begin
        m_lives = m_lives - 1;
        m_mode = (m_lives == 0) ? 2 : 1;
        m_frames = 0;
      end else if (sof && (l != r)) begin
        m_xfp = m_xfp + (r ? 128 : -128);
        if (m_xfp < 0) m_xfp = 0;
        if (m_xfp > 608 * 64) m_xfp = 608 * 64;
      end
    end else if (m_mode == 1) begin
      if (sof) begin
        m_frames++;
        if (m_frames == 60) m_mode = 0;
      end
    end
    e.x     = m_xfp / 64;
    e.vis   = (m_mode == 0) ? 1 : (m_mode == 1) ? ((m_frames / 8) % 2) : 0;
    e.lives = m_lives;
    e.over  = (m_mode == 2) ? 1 : 0;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input bit rst, input bit sof, input bit l, input bit r, input bit hit);
    @(negedge clk);
    #1;
    reset = rst; startOfFrame = sof; moveLeft = l; moveRight = r; playerHit = hit;
    model_step(rst, sof, l, r, hit);
  endtask

  // One frame: pulse with the given keys, then idle cycles with noisy keys.
  task automatic frame(input bit l, input bit r, input bit hit);
    cyc(1'b0, 1'b1, l, r, hit);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'($urandom), 1'($urandom), 1'b0);
  endtask

  task automatic frames(input int n, input bit l, input bit r);
    for (int i = 0; i < n; i++) frame(l, r, 1'b0);
  endtask

  initial begin : stim
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    frames(3, 1'b0, 1'b1);
    frames(200, 1'b1, 1'b0);
    frames(400, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    frames(10, 1'b1, 1'b1);
    // Hit coincident with a moving frame, then a second hit during HIT.
    frame(1'b0, 1'b1, 1'b1);
    frames(19, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    frame(1'b0, 1'b1, 1'b1);
    frames(45, 1'b0, 1'b1);
    frame(1'b0, 1'b0, 1'b1);
    frames(65, 1'b1, 1'b0);
    frame(1'b0, 1'b0, 1'b1);
    frames(10, 1'b0, 1'b1);
    // Reset during HIT.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    frame(1'b0, 1'b0, 1'b1);
    frames(5, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    frame(1'b0, 1'b1, 1'b0);
    // Reach DEAD, then reset.
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      frames(62, 1'b1, 1'b0);
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    frame(1'b1, 1'b0, 1'b0);
    // Randomized traffic.
    for (int i = 0; i < 6000; i++)
      cyc(1'(($urandom % 700) == 0), 1'(($urandom % 4) == 0), 1'($urandom),
          1'($urandom), 1'(($urandom % 60) == 0));
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/player_movement.md
# player_movement

Per-frame position and life controller for the player ship. It sits directly upstream of the player's square-object/bitmap drawing stage and drives that stage's `topLeftX`/`topLeftY`. A `visible` flag gates the stage's `drawingRequest`. The block integrates left/right key input once per video frame in fixed-point, clamps the ship to the screen, and runs a hit/invulnerability/blink/game-over state machine.

## Interface
Parameters:
- `INITIAL_X`, 300: reset/start top-left X, in pixels.
- `INITIAL_Y`, 420: constant top-left Y, in pixels.
- `OBJECT_WIDTH_X`, 32: ship width, used for the right clamp.
- `SCREEN_LEFT`, 0: leftmost legal pixel column.
- `SCREEN_RIGHT`, 639: rightmost legal pixel column.
- `FIXED_POINT_MULTIPLIER`, 64: sub-pixel scale, a power of two.
- `X_SPEED`, 128: fixed-point units moved per frame (2 px).
- `LIVES`, 3: initial life count, range 1..7.
- `HIT_FRAMES`, 60: invulnerability length, in frames.
- `BLINK_FRAMES`, 8: blink half-period, in frames.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `startOfFrame` in 1: one-cycle pulse, once per VGA frame.
- `moveLeft` in 1: level, left key held.
- `moveRight` in 1: level, right key held.
- `playerHit` in 1: one-cycle pulse from collision detection.
- `topLeftX` out `coordinate` (11-bit signed): ship top-left X.
- `topLeftY` out `coordinate`: ship top-left Y.
- `visible` out 1: ship may be drawn this frame.
- `livesLeft` out 3: remaining lives.
- `gameOver` out 1: sticky, set when lives reach 0.

## Operation
- Internal state: `xFP`, 17-bit signed, equal to pixel X × `FIXED_POINT_MULTIPLIER`.
- Output derivation: `topLeftX = xFP >>> log2(FIXED_POINT_MULTIPLIER)`, truncating toward −∞. `topLeftY` is constant `INITIAL_Y`.
- Legal X range: `MIN_FP = SCREEN_LEFT*FPM` and `MAX_FP = (SCREEN_RIGHT+1-OBJECT_WIDTH_X)*FPM`, i.e. 608 px with the defaults.
- Movement happens only on `startOfFrame` and only in ALIVE:
  - `moveLeft` alone: `xFP -= X_SPEED`, saturate at `MIN_FP`.
  - `moveRight` alone: `xFP += X_SPEED`, saturate at `MAX_FP`.
  - Both keys or neither: no change.
  - Comparisons are done in 18-bit signed so they never overflow.
- State machine `{ALIVE, HIT, DEAD}`:
  - ALIVE, `playerHit` seen:
    - `livesLeft` decrements.
    - If the new value is 0: go to DEAD.
    - Otherwise: go to HIT, clear `hitCnt` and `blinkCnt`, set `visible=0`.
  - HIT, each `startOfFrame`:
    - `hitCnt++` and `blinkCnt++`.
    - When `blinkCnt == BLINK_FRAMES-1`, toggle `visible` and clear `blinkCnt`.
    - When `hitCnt == HIT_FRAMES-1`, go to ALIVE with `visible=1`.
  - HIT: `playerHit` is ignored (invulnerable). Position is frozen.
  - DEAD: absorbing. `visible=0`, `gameOver=1`, `playerHit` ignored, position frozen. Only `reset` leaves DEAD.
- Counters: `hitCnt` and `blinkCnt` are wide enough for the parameters (≥6 and ≥4 bits for the defaults).

## Timing
- All outputs are registered. Every update is visible in the cycle after the triggering pulse.
- Reset values, applied on the first rising edge with `reset=1`:
  - state ALIVE
  - `xFP = INITIAL_X*FPM`, so `topLeftX = INITIAL_X`
  - `topLeftY = INITIAL_Y`
  - `visible = 1`
  - `livesLeft = LIVES`
  - `gameOver = 0`
  - counters 0
- Reset mid-HIT or in DEAD restores all of the above. There is no residual invulnerability.
- `playerHit` and `startOfFrame` in the same ALIVE cycle: the hit wins and no movement is applied for that frame. The HIT frame count starts with the next `startOfFrame`.
- HIT lasts exactly `HIT_FRAMES` `startOfFrame` pulses. The ALIVE transition and `visible=1` land one cycle after the `HIT_FRAMES`-th pulse.
- `moveLeft`/`moveRight` are sampled only in the `startOfFrame` cycle. Key changes between pulses have no effect.
- `topLeftX` changes at most once per frame, so the downstream drawing stage sees a stable position within each frame.

## Test plan
- Reset, then 3 frames with `moveRight=1` → `topLeftX` = 302, 304, 306, each one cycle after its `startOfFrame`; `visible=1`, `livesLeft=3`.
- Hold `moveLeft=1` for 200 frames → `topLeftX` saturates at 0, never negative. Hold `moveRight` for 400 frames → `topLeftX` saturates at 608.
- `moveLeft` and `moveRight` both high for 10 frames → `topLeftX` stays 300.
- `playerHit` pulse in ALIVE, coincident with `startOfFrame` while `moveRight=1`:
  - Next cycle: `livesLeft=2`, `visible=0`, `topLeftX` unchanged.
  - `visible` toggles after frames 8, 16, … .
  - A second `playerHit` at frame 20 is ignored.
  - `visible=1` and movement resume after frame 60.
- Three hits, each separated by more than 60 frames → `livesLeft` goes 2, 1, 0. On the third hit, `gameOver=1` and `visible=0` the next cycle. Later frames with movement keys held leave `topLeftX` frozen.
- Assert `reset` for one cycle while in HIT and again while in DEAD → all outputs return to their reset values on the next cycle, and movement works on the following frame.
